// File: rtl/gb_snd_pkg.sv
// Shared definitions for the sound block: channel-3 register addresses, wave RAM window,
// read-back masks and the channel-3 control state encoding.
package gb_snd_pkg;

  localparam logic [15:0] AddrNr30      = 16'hFF1A;
  localparam logic [15:0] AddrNr31      = 16'hFF1B;
  localparam logic [15:0] AddrNr32      = 16'hFF1C;
  localparam logic [15:0] AddrNr33      = 16'hFF1D;
  localparam logic [15:0] AddrNr34      = 16'hFF1E;
  localparam logic [15:0] AddrWaveBase  = 16'hFF30;
  localparam logic [15:0] AddrWaveLimit = 16'hFF3F;

  // Bits that always read back as 1 (unimplemented or write-only fields).
  localparam logic [7:0] MaskNr30 = 8'h7F;
  localparam logic [7:0] MaskNr31 = 8'hFF;
  localparam logic [7:0] MaskNr32 = 8'h9F;
  localparam logic [7:0] MaskNr33 = 8'hFF;
  localparam logic [7:0] MaskNr34 = 8'hBF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StTrig = 2'd1,
    StRun  = 2'd2
  } ch3_state_e;

  function automatic logic is_wave_addr(input logic [15:0] addr);
    return (addr >= AddrWaveBase) && (addr <= AddrWaveLimit);
  endfunction

  function automatic logic is_ch3_reg_addr(input logic [15:0] addr);
    return (addr >= AddrNr30) && (addr <= AddrNr34);
  endfunction

endpackage

// File: rtl/ch3_freq_timer.sv
// Channel-3 frequency timer. A prescaler divides clk by CLK_DIV; each prescaler wrap advances
// an 11-bit up-counter that starts at the frequency value and ends its period at 2047, giving
// a period of (2048 - freq) * CLK_DIV clk cycles. The frequency is sampled only at reloads.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en_i        count enable (channel running)
//   reload_i    restart the period from freq_i
//   kill_i      suppress a tick that would be issued this cycle
//   freq_i      11-bit frequency value
//   tick_o      registered one-cycle pulse at each period end
module ch3_freq_timer #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  input  logic        reload_i,
  input  logic        kill_i,
  input  logic [10:0] freq_i,
  output logic        tick_o
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  logic [DivW-1:0] div_q;
  logic [10:0]     cnt_q;
  logic            tick_q;
  logic            step;
  logic            period_end;

  assign step       = (div_q == DivLast);
  assign period_end = en_i & step & (cnt_q == 11'h7FF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= period_end & ~kill_i;
      if (reload_i) begin
        div_q <= '0;
        cnt_q <= freq_i;
      end else if (en_i) begin
        if (step) begin
          div_q <= '0;
          cnt_q <= (cnt_q == 11'h7FF) ? freq_i : cnt_q + 11'd1;
        end else begin
          div_q <= div_q + 1'b1;
        end
      end
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/ch3_wave_regs.sv
// Channel-3 CPU-side register block: decodes NR30-NR34 (0xFF1A-0xFF1E) and wave RAM
// (0xFF30-0xFF3F), holds the 128-bit sample store and control registers, and generates the
// trigger pulse and sample-advance tick for the waveform player.
// Optional build macro CH3_WAVE_LOCK_EN: while the channel is not idle, wave RAM writes are
// ignored and wave reads return 0xFF (bus_hit still asserts).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   bus_addr_i/wr/rd/data  CPU bus access, one-cycle strobes
//   bus_rd_data_o          registered read data (0xFF after reset)
//   bus_hit_o              registered, high the cycle after an owned access
//   ch3_*_o                decoded control fields and packed wave samples
//   ch3_reset_o            trigger pulse, TRIG_HOLD cycles
//   sample_tick_o          one-cycle sample advance pulse
module ch3_wave_regs
  import gb_snd_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned TRIG_HOLD = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  bus_addr_i,
  input  logic         bus_wr_en_i,
  input  logic         bus_rd_en_i,
  input  logic [7:0]   bus_wr_data_i,
  output logic [7:0]   bus_rd_data_o,
  output logic         bus_hit_o,
  output logic         ch3_enable_o,
  output logic [7:0]   ch3_length_data_o,
  output logic [1:0]   ch3_output_level_o,
  output logic         ch3_dont_loop_o,
  output logic [10:0]  ch3_frequency_data_o,
  output logic [127:0] ch3_samples_o,
  output logic         ch3_reset_o,
  output logic         sample_tick_o
);

  localparam int unsigned HoldW = (TRIG_HOLD > 1) ? $clog2(TRIG_HOLD) : 1;
  // Counter runs TRIG_HOLD-1 down to 0, so ch3_reset is high for exactly TRIG_HOLD cycles.
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(TRIG_HOLD - 1);

  logic         nr30_en_q;
  logic [7:0]   nr31_q;
  logic [1:0]   nr32_level_q;
  logic [7:0]   nr33_q;
  logic         nr34_dont_loop_q;
  logic [2:0]   nr34_freq_hi_q;
  logic [127:0] wave_q;
  logic [7:0]   rd_data_q;
  logic         hit_q;

  ch3_state_e     state_q;
  logic [HoldW-1:0] hold_q;
  logic           ch3_reset_q;

  logic       wave_sel;
  logic       owned;
  logic [6:0] wave_bit;
  logic [7:0] wave_byte;
  logic       wave_locked;
  logic [7:0] rd_val;
  logic       wr_nr30;
  logic       wr_nr34;
  logic       trig_wr;
  logic       trig_go;
  logic       dac_off_wr;
  logic       timer_reload;
  logic       timer_en;
  logic       timer_kill;
  logic       tick;

  assign wave_sel  = is_wave_addr(bus_addr_i);
  assign owned     = wave_sel | is_ch3_reg_addr(bus_addr_i);
  assign wave_bit  = {bus_addr_i[3:0], 3'b000};
  assign wave_byte = wave_q[wave_bit +: 8];

`ifdef CH3_WAVE_LOCK_EN
  assign wave_locked = (state_q != StIdle);
`else
  assign wave_locked = 1'b0;
`endif

  assign wr_nr30    = bus_wr_en_i & (bus_addr_i == AddrNr30);
  assign wr_nr34    = bus_wr_en_i & (bus_addr_i == AddrNr34);
  assign trig_wr    = wr_nr34 & bus_wr_data_i[7];
  assign trig_go    = trig_wr & nr30_en_q;
  assign dac_off_wr = wr_nr30 & ~bus_wr_data_i[7];

  // Read value is built from current register contents, so a same-cycle write is not seen.
  always_comb begin
    rd_val = 8'hFF;
    case (bus_addr_i)
      AddrNr30: rd_val = {nr30_en_q, 7'b0} | MaskNr30;
      AddrNr31: rd_val = MaskNr31;
      AddrNr32: rd_val = {1'b0, nr32_level_q, 5'b0} | MaskNr32;
      AddrNr33: rd_val = MaskNr33;
      AddrNr34: rd_val = {1'b0, nr34_dont_loop_q, 6'b0} | MaskNr34;
      default: begin
        // Stored nibbles are swapped so the high nibble sits in the lower sample slot.
        if (wave_sel && !wave_locked) rd_val = {wave_byte[3:0], wave_byte[7:4]};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nr30_en_q        <= 1'b0;
      nr31_q           <= '0;
      nr32_level_q     <= '0;
      nr33_q           <= '0;
      nr34_dont_loop_q <= 1'b0;
      nr34_freq_hi_q   <= '0;
      wave_q           <= '0;
      rd_data_q        <= 8'hFF;
      hit_q            <= 1'b0;
    end else begin
      hit_q <= (bus_rd_en_i | bus_wr_en_i) & owned;
      if (bus_rd_en_i && owned) rd_data_q <= rd_val;
      if (bus_wr_en_i) begin
        case (bus_addr_i)
          AddrNr30: nr30_en_q    <= bus_wr_data_i[7];
          AddrNr31: nr31_q       <= bus_wr_data_i;
          AddrNr32: nr32_level_q <= bus_wr_data_i[6:5];
          AddrNr33: nr33_q       <= bus_wr_data_i;
          AddrNr34: begin
            nr34_dont_loop_q <= bus_wr_data_i[6];
            nr34_freq_hi_q   <= bus_wr_data_i[2:0];
          end
          default: begin
            if (wave_sel && !wave_locked) begin
              wave_q[wave_bit +: 8] <= {bus_wr_data_i[3:0], bus_wr_data_i[7:4]};
            end
          end
        endcase
      end
    end
  end

  // Channel control FSM. Turning the DAC off has priority over everything, then triggers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      ch3_reset_q <= 1'b0;
    end else if (dac_off_wr) begin
      state_q     <= StIdle;
      ch3_reset_q <= 1'b0;
    end else if (trig_go) begin
      state_q     <= StTrig;
      hold_q      <= HoldLoad;
      ch3_reset_q <= 1'b1;
    end else begin
      case (state_q)
        StTrig: begin
          if (hold_q == '0) begin
            state_q     <= StRun;
            ch3_reset_q <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign timer_reload = (state_q == StTrig) && (hold_q == '0) && !dac_off_wr && !trig_go;
  assign timer_en     = (state_q == StRun);
  assign timer_kill   = trig_wr | dac_off_wr;

  ch3_freq_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_freq_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (timer_en),
    .reload_i (timer_reload),
    .kill_i   (timer_kill),
    .freq_i   ({nr34_freq_hi_q, nr33_q}),
    .tick_o   (tick)
  );

  assign bus_rd_data_o        = rd_data_q;
  assign bus_hit_o            = hit_q;
  assign ch3_enable_o         = nr30_en_q;
  assign ch3_length_data_o    = nr31_q;
  assign ch3_output_level_o   = nr32_level_q;
  assign ch3_dont_loop_o      = nr34_dont_loop_q;
  assign ch3_frequency_data_o = {nr34_freq_hi_q, nr33_q};
  assign ch3_samples_o        = wave_q;
  assign ch3_reset_o          = ch3_reset_q;
  assign sample_tick_o        = tick;

endmodule

// File: tb/tb_ch3_wave_regs.sv
// Directed bench for ch3_wave_regs (CLK_DIV=2, TRIG_HOLD=4). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_ch3_wave_regs;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  bus_addr;
  logic         bus_wr_en;
  logic         bus_rd_en;
  logic [7:0]   bus_wr_data;
  logic [7:0]   bus_rd_data;
  logic         bus_hit;
  logic         ch3_enable;
  logic [7:0]   ch3_length_data;
  logic [1:0]   ch3_output_level;
  logic         ch3_dont_loop;
  logic [10:0]  ch3_frequency_data;
  logic [127:0] ch3_samples;
  logic         ch3_reset;
  logic         sample_tick;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ch3_wave_regs #(
    .CLK_DIV   (2),
    .TRIG_HOLD (4)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bus_addr_i           (bus_addr),
    .bus_wr_en_i          (bus_wr_en),
    .bus_rd_en_i          (bus_rd_en),
    .bus_wr_data_i        (bus_wr_data),
    .bus_rd_data_o        (bus_rd_data),
    .bus_hit_o            (bus_hit),
    .ch3_enable_o         (ch3_enable),
    .ch3_length_data_o    (ch3_length_data),
    .ch3_output_level_o   (ch3_output_level),
    .ch3_dont_loop_o      (ch3_dont_loop),
    .ch3_frequency_data_o (ch3_frequency_data),
    .ch3_samples_o        (ch3_samples),
    .ch3_reset_o          (ch3_reset),
    .sample_tick_o        (sample_tick)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_addr = a; bus_wr_data = d; bus_wr_en = 1'b1;
    @(negedge clk);
    bus_wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic h);
    @(negedge clk);
    bus_addr = a; bus_rd_en = 1'b1;
    @(negedge clk);
    bus_rd_en = 1'b0;
    d = bus_rd_data; h = bus_hit;
  endtask

  task automatic bus_rdwr(input logic [15:0] a, input logic [7:0] wd, output logic [7:0] d);
    @(negedge clk);
    bus_addr = a; bus_wr_data = wd; bus_rd_en = 1'b1; bus_wr_en = 1'b1;
    @(negedge clk);
    bus_rd_en = 1'b0; bus_wr_en = 1'b0;
    d = bus_rd_data;
  endtask

  // Returns the cycle stamp of the next tick (current sample included), or -1 on timeout.
  task automatic wait_tick(input int limit, output int t);
    int n = 0;
    while (!sample_tick && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sample_tick) begin
      t = cyc;
      @(negedge clk);
    end else begin
      t = -1;
    end
  endtask

  logic [7:0] rd;
  logic       hit;
  int         n_hi, n_tk, first, t0, t1, t2;

  initial begin
    rst_n = 1'b0; bus_addr = '0; bus_wr_en = 1'b0; bus_rd_en = 1'b0; bus_wr_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_samples", ch3_samples, '0);
    check("rst_rd_data", bus_rd_data, 8'hFF);
    check("rst_hit", bus_hit, 1'b0);
    check("rst_reset", ch3_reset, 1'b0);
    check("rst_tick", sample_tick, 1'b0);
    check("rst_enable", ch3_enable, 1'b0);
    check("rst_freq", ch3_frequency_data, 11'h000);

    bus_read(16'hFF1B, rd, hit);
    check("nr31_rd", rd, 8'hFF);
    check("nr31_hit", hit, 1'b1);

    bus_write(16'hFF30, 8'hA5);
    check("wr_hit", bus_hit, 1'b1);
    check("wave_hi_nib", ch3_samples[3:0], 4'hA);
    check("wave_lo_nib", ch3_samples[7:4], 4'h5);
    bus_read(16'hFF30, rd, hit);
    check("wave_rd", rd, 8'hA5);

    bus_write(16'hFF1C, 8'h40);
    check("level", ch3_output_level, 2'd2);
    bus_read(16'hFF1C, rd, hit);
    check("nr32_rd", rd, 8'hDF);

    bus_write(16'hFF1B, 8'h3C);
    check("length", ch3_length_data, 8'h3C);
    bus_read(16'hFF1B, rd, hit);
    check("nr31_rd_mask", rd, 8'hFF);

    bus_write(16'hFF1E, 8'h46);
    check("dont_loop", ch3_dont_loop, 1'b1);
    check("freq_hi", ch3_frequency_data, 11'h600);
    check("no_trig_dac_off", ch3_reset, 1'b0);
    bus_read(16'hFF1E, rd, hit);
    check("nr34_rd", rd, 8'hFF);

    bus_read(16'hFF1A, rd, hit);
    check("nr30_rd_off", rd, 8'h7F);
    bus_read(16'hFF20, rd, hit);
    check("unowned_rd", rd, 8'h7F);
    check("unowned_hit", hit, 1'b0);

    bus_write(16'hFF32, 8'h77);
    bus_rdwr(16'hFF32, 8'h11, rd);
    check("rdwr_old", rd, 8'h77);
    bus_read(16'hFF32, rd, hit);
    check("rdwr_new", rd, 8'h11);

    // Trigger with DAC on, freq 0x7FF.
    bus_write(16'hFF1A, 8'h80);
    bus_read(16'hFF1A, rd, hit);
    check("nr30_rd_on", rd, 8'hFF);
    bus_write(16'hFF1D, 8'hFF);
    bus_write(16'hFF1E, 8'h87);
    n_hi = 0;
    while (ch3_reset && n_hi < 20) begin
      n_hi++;
      @(negedge clk);
    end
    check("trig_hold", n_hi, 4);
    n_tk = 0; first = -1;
    for (int i = 0; i < 12; i++) begin
      if (sample_tick) begin
        n_tk++;
        if (first < 0) first = i;
      end
      @(negedge clk);
    end
    check("first_tick", first, 2);
    check("tick_count", n_tk, 5);
    check("freq_7ff", ch3_frequency_data, 11'h7FF);

    // Wave access while running.
    bus_write(16'hFF31, 8'h12);
    bus_read(16'hFF31, rd, hit);
    check("run_wave_hit", hit, 1'b1);
`ifdef CH3_WAVE_LOCK_EN
    check("run_wave_locked", ch3_samples[15:8], 8'h00);
    check("run_wave_rd", rd, 8'hFF);
`else
    check("run_wave_stored", ch3_samples[15:8], 8'h21);
    check("run_wave_rd", rd, 8'h12);
`endif

    // DAC off stops ticks; retrigger with DAC off does nothing.
    bus_write(16'hFF1A, 8'h00);
    check("dac_off", ch3_enable, 1'b0);
    n_tk = 0;
    for (int i = 0; i < 20; i++) begin
      if (sample_tick) n_tk++;
      @(negedge clk);
    end
    check("no_ticks_off", n_tk, 0);
    bus_write(16'hFF1E, 8'h80);
    n_hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (ch3_reset) n_hi++;
      @(negedge clk);
    end
    check("retrig_dac_off", n_hi, 0);

    bus_write(16'hFF31, 8'h12);
    check("idle_wave_stored", ch3_samples[15:8], 8'h21);
    bus_read(16'hFF31, rd, hit);
    check("idle_wave_rd", rd, 8'h12);

    // Period change mid-period applies at the next reload.
    bus_write(16'hFF1A, 8'h80);
    bus_write(16'hFF1D, 8'h00);
    bus_write(16'hFF1E, 8'h80);
    check("freq_000", ch3_frequency_data, 11'h000);
    wait_tick(10000, t0);
    check("tick0_seen", (t0 >= 0), 1'b1);
    repeat (100) @(negedge clk);
    bus_write(16'hFF1D, 8'hF0);
    check("freq_0f0", ch3_frequency_data, 11'h0F0);
    wait_tick(5000, t1);
    wait_tick(5000, t2);
    check("period_old", t1 - t0, 4096);
    check("period_new", t2 - t1, (2048 - 240) * 2);

    // Asynchronous reset during a trigger pulse.
    bus_write(16'hFF1E, 8'h80);
    check("trig_again", ch3_reset, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_reset", ch3_reset, 1'b0);
    check("async_rst_en", ch3_enable, 1'b0);
    check("async_rst_samples", ch3_samples, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
